// File: rtl/sd_word_serializer_pkg.sv
// Shared definitions for the sd_* blocks: serializer FSM encoding, detector
// state constants and a small sizing helper.
package sd_word_serializer_pkg;

    localparam logic [1:0] SER_IDLE  = 2'b00;
    localparam logic [1:0] SER_SHIFT = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = SER_IDLE,
        ST_SHIFT = SER_SHIFT
    } ser_state_t;

    // Sequence-detector state constants, kept here so every sd_* block agrees.
    localparam logic [1:0] DET_S0 = 2'b00;
    localparam logic [1:0] DET_S1 = 2'b01;
    localparam logic [1:0] DET_S2 = 2'b10;
    localparam logic [1:0] DET_S3 = 2'b11;

    function automatic int cnt_width(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/sd_bit_counter.sv
// Modulo-MODULUS up-counter with synchronous clear and a terminal-count flag;
// tracks which bit of the current word is on the serial line.
module sd_bit_counter #(
    parameter int MODULUS = 8,
    parameter int CW      = 3
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(MODULUS - 1);

    assign tc = (cnt == TC_VAL);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sd_word_serializer.sv
// Parallel-to-serial feeder for the sequence detectors: valid/ready word input,
// one registered bit per clock with framing flags and a saturating word count.
module sd_word_serializer
    import sd_word_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic [CNT_W-1:0] words_sent
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("sd_word_serializer: WIDTH must be in 2..32");
    end

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

    ser_state_t       state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic             cnt_tc;
    logic             accept;
    logic             load, step, stop;

    assign in_ready = (state == ST_IDLE) || (state == ST_SHIFT && cnt_tc);
    assign accept   = in_valid && in_ready;

    sd_bit_counter #(
        .MODULUS (WIDTH),
        .CW      (CW)
    ) u_bit_counter (
        .clk    (clk),
        .areset (areset),
        .clear  (load || stop),
        .inc    (step),
        .cnt    (bit_cnt),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        stop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!cnt_tc) begin
                    step = 1'b1;
                end else if (accept) begin
                    load = 1'b1;
                end else begin
                    stop      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // shreg holds the bits still to be sent, already aligned so the next one
    // sits at the outgoing end; x_out is the bit currently on the line.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            shreg     <= '0;
            x_out     <= IDLE_BIT;
            bit_valid <= 1'b0;
            first_bit <= 1'b0;
            last_bit  <= 1'b0;
        end else if (load) begin
            shreg     <= MSB_FIRST ? (in_data << 1) : (in_data >> 1);
            x_out     <= MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
            bit_valid <= 1'b1;
            first_bit <= 1'b1;
            last_bit  <= 1'b0;
        end else if (step) begin
            shreg     <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            x_out     <= MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
            first_bit <= 1'b0;
            last_bit  <= (bit_cnt == PRE_LAST);
        end else if (stop) begin
            x_out     <= IDLE_BIT;
            bit_valid <= 1'b0;
            first_bit <= 1'b0;
            last_bit  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            words_sent <= '0;
        end else if (state == ST_SHIFT && cnt_tc && words_sent != '1) begin
            words_sent <= words_sent + CNT_W'(1);
        end
    end

endmodule
